// File: rtl/cuadratura_pkg.sv
// Shared definitions for the quadrature decoder: Gray positions, step kinds
// and the {previous, next} -> step mapping.
package cuadratura_pkg;

    localparam logic [1:0] POS_00 = 2'b00;
    localparam logic [1:0] POS_01 = 2'b01;
    localparam logic [1:0] POS_11 = 2'b11;
    localparam logic [1:0] POS_10 = 2'b10;

    localparam int FILTRO_N_DEF = 4;
    localparam int ANCHO_F_DEF  = 8;

    typedef enum logic [1:0] {
        PASO_NINGUNO,
        PASO_UP,
        PASO_DOWN,
        PASO_ERROR
    } paso_t;

    // Next position in the forward direction: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] siguiente_pos(input logic [1:0] pos);
        logic [1:0] sig;
        case (pos)
            POS_00:  sig = POS_01;
            POS_01:  sig = POS_11;
            POS_11:  sig = POS_10;
            default: sig = POS_00;
        endcase
        return sig;
    endfunction

    function automatic paso_t decodificar_paso(input logic [1:0] previo,
                                               input logic [1:0] nuevo);
        paso_t paso;
        if (nuevo == previo)
            paso = PASO_NINGUNO;
        else if (nuevo == siguiente_pos(previo))
            paso = PASO_UP;
        else if (previo == siguiente_pos(nuevo))
            paso = PASO_DOWN;
        else
            paso = PASO_ERROR;
        return paso;
    endfunction

endpackage

// File: rtl/decodificador_cuadratura_if.sv
// Encoder-side bundle: raw A/B channels in, step strobes and filtered state out.
interface decodificador_cuadratura_if;

    logic       a;
    logic       b;
    logic       up;
    logic       down;
    logic       error;
    logic [1:0] estado;
    logic       valido;

    modport master (
        output a, b,
        input  up, down, error, estado, valido
    );

    modport slave (
        input  a, b,
        output up, down, error, estado, valido
    );

endinterface

// File: rtl/sincronizador_filtro.sv
// Two-flop synchronizer per bit followed by a stability filter that accepts a
// new value only after it has been seen unchanged for FILTRO_N cycles.
module sincronizador_filtro
    import cuadratura_pkg::*;
#(
    parameter int ANCHO    = 2,
    parameter int FILTRO_N = FILTRO_N_DEF,
    parameter int ANCHO_F  = ANCHO_F_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ANCHO-1:0] din,
    input  logic             cebado,
    output logic [ANCHO-1:0] valor,
    output logic [ANCHO-1:0] candidato,
    output logic             nuevo
);

    localparam logic [ANCHO_F-1:0] UNO    = ANCHO_F'(1);
    localparam logic [ANCHO_F-1:0] LIMITE = ANCHO_F'(FILTRO_N);

    logic [ANCHO-1:0]   sinc;
    logic [ANCHO-1:0]   previo_reg;
    logic [ANCHO-1:0]   valor_reg;
    logic [ANCHO_F-1:0] cuenta_reg;
    logic [ANCHO_F-1:0] cuenta_next;
    logic               cargar;

    for (genvar gi = 0; gi < ANCHO; gi++) begin : g_sinc
        logic etapa1_reg;
        logic etapa2_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                etapa1_reg <= 1'b0;
                etapa2_reg <= 1'b0;
            end else begin
                etapa1_reg <= din[gi];
                etapa2_reg <= etapa1_reg;
            end
        end

        assign sinc[gi] = etapa2_reg;
    end

    // The cycle in which a new value first appears counts as its first stable
    // cycle, so a clean change is accepted exactly FILTRO_N cycles after it
    // reaches the synchronizer output. Before priming, a value equal to the
    // current state is also counted so the resting position gets loaded.
    always_comb begin
        cuenta_next = cuenta_reg;
        cargar      = 1'b0;
        if (cebado && (sinc == valor_reg)) begin
            cuenta_next = '0;
        end else begin
            if (sinc != previo_reg)
                cuenta_next = UNO;
            else
                cuenta_next = cuenta_reg + UNO;
            if (cuenta_next == LIMITE) begin
                cargar      = 1'b1;
                cuenta_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            previo_reg <= '0;
            valor_reg  <= '0;
            cuenta_reg <= '0;
        end else begin
            previo_reg <= sinc;
            cuenta_reg <= cuenta_next;
            if (cargar)
                valor_reg <= sinc;
        end
    end

    assign valor     = valor_reg;
    assign candidato = sinc;
    assign nuevo     = cargar;

endmodule

// File: rtl/decodificador_cuadratura.sv
// Quadrature decoder: filters raw A/B, primes on the first stable value after
// reset, then emits one registered up/down/error strobe per accepted step.
module decodificador_cuadratura
    import cuadratura_pkg::*;
#(
    parameter int FILTRO_N = FILTRO_N_DEF,
    parameter int ANCHO_F  = ANCHO_F_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    decodificador_cuadratura_if.slave   bus
);

    logic [1:0] valor;
    logic [1:0] candidato;
    logic       nuevo;
    paso_t      paso;

    logic up_reg, up_next;
    logic down_reg, down_next;
    logic error_reg, error_next;
    logic valido_reg, valido_next;

    sincronizador_filtro #(
        .ANCHO    (2),
        .FILTRO_N (FILTRO_N),
        .ANCHO_F  (ANCHO_F)
    ) u_filtro (
        .clk       (clk),
        .reset     (reset),
        .din       ({bus.a, bus.b}),
        .cebado    (valido_reg),
        .valor     (valor),
        .candidato (candidato),
        .nuevo     (nuevo)
    );

    // Decoded against the value about to be replaced, so the strobe lands on
    // the same edge that updates estado.
    assign paso = decodificar_paso(valor, candidato);

    always_comb begin
        up_next     = 1'b0;
        down_next   = 1'b0;
        error_next  = 1'b0;
        valido_next = valido_reg | nuevo;
        if (nuevo && valido_reg) begin
            case (paso)
                PASO_UP:    up_next    = 1'b1;
                PASO_DOWN:  down_next  = 1'b1;
                PASO_ERROR: error_next = 1'b1;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_reg     <= 1'b0;
            down_reg   <= 1'b0;
            error_reg  <= 1'b0;
            valido_reg <= 1'b0;
        end else begin
            up_reg     <= up_next;
            down_reg   <= down_next;
            error_reg  <= error_next;
            valido_reg <= valido_next;
        end
    end

    assign bus.up     = up_reg;
    assign bus.down   = down_reg;
    assign bus.error  = error_reg;
    assign bus.estado = valor;
    assign bus.valido = valido_reg;

endmodule

// File: doc/decodificador_cuadratura.md
Name: decodificador_cuadratura

Overview:
- Produces the one-cycle `up`/`down` strobes consumed by the team's up/down counters (contador family).
- Takes raw A/B quadrature signals from a rotary encoder or pushbutton pair on EDU-CIAA-FPGA pins.
- Synchronizes and glitch-filters the signals, tracks the 2-bit Gray position and emits exactly one `up` or `down` pulse per legal step.
- Flags illegal double-bit jumps on `error` instead of counting them.

Parameters:
- FILTRO_N, 4, consecutive clock cycles a new synchronized A/B value must stay stable before it is accepted; legal range 1..255.
- ANCHO_F, 8, width of the internal stability counter; must satisfy 2^ANCHO_F > FILTRO_N.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  1  raw encoder channel A, asynchronous to clk.
- b  input  1  raw encoder channel B, asynchronous to clk.
- up  output  1  one-cycle strobe, one forward step accepted.
- down  output  1  one-cycle strobe, one reverse step accepted.
- error  output  1  one-cycle strobe, illegal two-bit transition accepted.
- estado  output  2  current filtered {a,b} value.
- valido  output  1  high once the first filtered value after reset has been loaded.

Behaviour:
- Reset (reset=0, async):
  - sync flops = 00, filtered state = 00, stability counter = 0.
  - up = down = error = 0, valido = 0, estado = 00.
  - Reset asserted mid-filter discards any pending value.
- Synchronizer: 2 flops per channel. The raw value first captured at edge E appears at the synchronizer output after edge E+1.
- Stability filter:
  - While sync output equals estado: counter holds 0.
  - While sync output differs from estado and is unchanged from the previous cycle: counter increments.
  - Any change of the sync output (including back to estado) clears the counter.
  - When the counter reaches FILTRO_N, estado loads the sync value and the counter clears.
  - Net effect: a clean change captured at edge E updates estado and fires its strobe at edge E+1+FILTRO_N. The strobe is high for exactly one cycle.
- Priming:
  - After reset, valido=0 and the first candidate value is accepted on a stable run of FILTRO_N cycles, equal to estado or not.
  - That acceptance loads estado, sets valido=1 and emits no strobe.
  - Prevents a spurious error when the encoder rests at 11 after reset.
- Step decode, applied on each accepted update with valido=1:
  - Forward (up): 00→01, 01→11, 11→10, 10→00.
  - Reverse (down): 00→10, 10→11, 11→01, 01→00.
  - Both bits changed (00↔11, 01↔10): error=1, up=down=0, estado still updates to the new value.
- Output rules:
  - up, down and error are mutually exclusive and registered; never more than one high in a cycle.
  - At most one strobe per accepted update. Back-to-back steps need at least FILTRO_N+1 cycles each.
- Glitch handling:
  - Pulses shorter than FILTRO_N cycles at the sync output produce no strobe and leave estado unchanged.
  - A/B edges arriving together within one cycle are treated as a single two-bit change and produce error.

Decomposition:
- Shared package `cuadratura_pkg`:
  - Gray position constants POS_00, POS_01, POS_11, POS_10.
  - A function/table mapping {previous, next} to one of PASO_NINGUNO, PASO_UP, PASO_DOWN, PASO_ERROR.
  - Default FILTRO_N.
- One sub-module, `sincronizador_filtro`: parameterized width (2 here), holding the 2-flop synchronizer plus the stability counter. Outputs the accepted value and a one-cycle "nuevo" flag. The top level performs priming and step decode.

Test Plan (FILTRO_N=4, 10 ns clock):
- Reset hold then release with a=b=0 stable: after 5 cycles valido=1, estado=00, no strobe. Asserting reset mid-run returns all outputs to 0 immediately, asynchronously.
- Forward sequence 00→01→11→10→00, each held 10 cycles: exactly 4 up pulses, each 1 cycle wide, each 6 edges after its input change; down=error=0; estado tracks the inputs.
- Reverse sequence 00→10→11→01→00: exactly 4 down pulses, no up, estado ends 00; confirm the pulses drive contador_02 count from 0 to 12 (4'hC).
- Glitch: from 00, drive a=1 for 3 cycles then back to 0: no strobe, estado stays 00. The same glitch held 4+ cycles yields one up.
- Double jump 00→11 held 10 cycles: single error pulse, up=down=0, estado=11. The next step 11→10 yields a normal up.
- Priming at 11: hold a=b=1 through reset release: valido rises with estado=11 and no error strobe.
